// File: rtl/bomberman_pkg.sv
// ============================================================================
// Module : bomberman_pkg
// Brief  : Shared tile geometry, palette, slot state and span helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bomberman_pkg;

  localparam int TILE_W = 16;
  localparam int TILE_H = 16;

  localparam logic [11:0] COLOR_NONE      = 12'h000;
  localparam logic [11:0] COLOR_FLAME     = 12'hF80;
  localparam logic [11:0] COLOR_FADE_HOT  = 12'hFF0;
  localparam logic [11:0] COLOR_FADE_COOL = 12'hF00;

  typedef enum logic [0:0] {
    SLOT_IDLE    = 1'b0,
    SLOT_BURNING = 1'b1
  } slot_state_e;

  // Lower arm bound clamps at the screen edge instead of wrapping.
  function automatic logic [10:0] sub_sat0(input logic [10:0] a, input logic [10:0] b);
    return (a < b) ? 11'd0 : (a - b);
  endfunction

  function automatic logic in_span(input logic [10:0] p, input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (p >= lo) && (p <= hi);
  endfunction

  function automatic logic spans_overlap(input logic [10:0] a_lo, input logic [10:0] a_hi,
                                         input logic [10:0] b_lo, input logic [10:0] b_hi);
    return (a_lo <= b_hi) && (b_lo <= a_hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/explosion_slot.sv
// ============================================================================
// Module : explosion_slot
// Brief  : One explosion slot: coordinate storage, burn timer, flame region test.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module explosion_slot
  import bomberman_pkg::*;
#(
  parameter int unsigned EXPLOSION_TIME = 50000000,
  parameter int unsigned RANGE          = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture_i,
  input  logic [9:0]  cap_x_i,
  input  logic [9:0]  cap_y_i,
  input  logic [9:0]  v_x_i,
  input  logic [9:0]  v_y_i,
  input  logic [9:0]  b_x_i,
  input  logic [9:0]  b_y_i,
`ifdef EXPLOSION_FADE_EN
  output logic [31:0] timer_o,
`endif
  output logic        valid_o,
  output logic        valid_next_o,
  output logic        cover_o,
  output logic        hit_o
);

  localparam logic [31:0] LAST_TICK  = 32'(EXPLOSION_TIME - 1);
  localparam logic [10:0] ARM_BACK_X = 11'(TILE_W * RANGE);
  localparam logic [10:0] ARM_FWD_X  = 11'(TILE_W * (RANGE + 1) - 1);
  localparam logic [10:0] ARM_BACK_Y = 11'(TILE_H * RANGE);
  localparam logic [10:0] ARM_FWD_Y  = 11'(TILE_H * (RANGE + 1) - 1);
  localparam logic [10:0] BODY_W     = 11'(TILE_W - 1);
  localparam logic [10:0] BODY_H     = 11'(TILE_H - 1);

  slot_state_e state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_IDLE;
      timer_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      SLOT_IDLE: begin
        if (capture_i) begin
          state_d = SLOT_BURNING;
          timer_d = '0;
          x_d     = cap_x_i;
          y_d     = cap_y_i;
        end
      end
      SLOT_BURNING: begin
        if (timer_q == LAST_TICK) begin
          state_d = SLOT_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  // Flame geometry at 11 bits so the forward bounds never overflow.
  logic [10:0] w_x, w_y, w_vx, w_vy, w_bx, w_by;
  logic [10:0] w_h_lo, w_h_hi, w_row_hi, w_v_lo, w_v_hi, w_col_hi;
  logic        w_in_h, w_in_v, w_hit_h, w_hit_v;

  always_comb begin
    w_x      = {1'b0, x_q};
    w_y      = {1'b0, y_q};
    w_vx     = {1'b0, v_x_i};
    w_vy     = {1'b0, v_y_i};
    w_bx     = {1'b0, b_x_i};
    w_by     = {1'b0, b_y_i};
    w_h_lo   = sub_sat0(w_x, ARM_BACK_X);
    w_h_hi   = w_x + ARM_FWD_X;
    w_row_hi = w_y + BODY_H;
    w_v_lo   = sub_sat0(w_y, ARM_BACK_Y);
    w_v_hi   = w_y + ARM_FWD_Y;
    w_col_hi = w_x + BODY_W;
    w_in_h   = in_span(w_vx, w_h_lo, w_h_hi) && in_span(w_vy, w_y, w_row_hi);
    w_in_v   = in_span(w_vx, w_x, w_col_hi) && in_span(w_vy, w_v_lo, w_v_hi);
    w_hit_h  = spans_overlap(w_bx, w_bx + BODY_W, w_h_lo, w_h_hi) &&
               spans_overlap(w_by, w_by + BODY_H, w_y, w_row_hi);
    w_hit_v  = spans_overlap(w_bx, w_bx + BODY_W, w_x, w_col_hi) &&
               spans_overlap(w_by, w_by + BODY_H, w_v_lo, w_v_hi);
  end

  assign valid_o      = (state_q == SLOT_BURNING);
  assign valid_next_o = (state_d == SLOT_BURNING);
  assign cover_o      = valid_o && (w_in_h || w_in_v);
  assign hit_o        = valid_o && (w_hit_h || w_hit_v);
`ifdef EXPLOSION_FADE_EN
  assign timer_o      = timer_q;
`endif

endmodule

`default_nettype wire

// File: rtl/explosion_ctrl.sv
// ============================================================================
// Module : explosion_ctrl
// Brief  : Explosion slot pool, flame pixel renderer and player hit detection.
//          Optional colour fade over burn time under macro EXPLOSION_FADE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module explosion_ctrl
  import bomberman_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned EXPLOSION_TIME = 50000000,
  parameter int unsigned RANGE          = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        explosion_write_enable,
  input  logic [9:0]  exploding_bomb_x,
  input  logic [9:0]  exploding_bomb_y,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  output logic        explosion_on,
  output logic [11:0] rgb_out,
  output logic        player_hit,
  output logic        overflow,
  output logic [2:0]  active_count
);

  logic [NUM_SLOTS-1:0] w_valid, w_valid_next, w_cover, w_hit, w_capture;
  logic                 w_none_idle;
`ifdef EXPLOSION_FADE_EN
  logic [31:0]          w_timer [NUM_SLOTS];
`endif

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      explosion_slot #(
        .EXPLOSION_TIME (EXPLOSION_TIME),
        .RANGE          (RANGE)
      ) u_slot (
        .clk          (clk),
        .reset        (reset),
        .capture_i    (w_capture[i]),
        .cap_x_i      (exploding_bomb_x),
        .cap_y_i      (exploding_bomb_y),
        .v_x_i        (v_x),
        .v_y_i        (v_y),
        .b_x_i        (b_x),
        .b_y_i        (b_y),
`ifdef EXPLOSION_FADE_EN
        .timer_o      (w_timer[i]),
`endif
        .valid_o      (w_valid[i]),
        .valid_next_o (w_valid_next[i]),
        .cover_o      (w_cover[i]),
        .hit_o        (w_hit[i])
      );
    end
  endgenerate

  // Only slots idle this cycle are eligible; an expiring slot frees up next cycle.
  always_comb begin
    w_capture   = '0;
    w_none_idle = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!w_valid[i] && w_none_idle) begin
        w_capture[i] = explosion_write_enable;
        w_none_idle  = 1'b0;
      end
    end
  end

  logic [2:0]  count_d;
  logic [11:0] w_color;

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      count_d = count_d + 3'(w_valid_next[i]);
    end
  end

`ifdef EXPLOSION_FADE_EN
  localparam longint unsigned FADE_LIMIT = (longint'(EXPLOSION_TIME) * 3) / 4;

  logic [31:0] w_oldest;
  logic        w_found;

  // Oldest covering slot decides the colour; strict compare keeps lowest index on ties.
  always_comb begin
    w_oldest = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_cover[i] && (!w_found || (w_timer[i] > w_oldest))) begin
        w_oldest = w_timer[i];
        w_found  = 1'b1;
      end
    end
    w_color = (64'(w_oldest) < FADE_LIMIT) ? COLOR_FADE_HOT : COLOR_FADE_COOL;
  end
`else
  assign w_color = COLOR_FLAME;
`endif

  logic        on_q, on_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hit_q, hit_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  count_q;

  always_comb begin
    on_d  = |w_cover;
    rgb_d = on_d ? w_color : COLOR_NONE;
    hit_d = hit_q | (|w_hit);
    ovf_d = explosion_write_enable & w_none_idle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      on_q    <= 1'b0;
      rgb_q   <= COLOR_NONE;
      hit_q   <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      on_q    <= on_d;
      rgb_q   <= rgb_d;
      hit_q   <= hit_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign explosion_on = on_q;
  assign rgb_out      = rgb_q;
  assign player_hit   = hit_q;
  assign overflow     = ovf_q;
  assign active_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_explosion_ctrl.sv
// ============================================================================
// Module : tb_explosion_ctrl
// Brief  : Directed self-checking bench for explosion_ctrl (EXPLOSION_TIME=10).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_explosion_ctrl;

`ifdef EXPLOSION_FADE_EN
  localparam logic [11:0] C_ON = 12'hFF0;
`else
  localparam logic [11:0] C_ON = 12'hF80;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [9:0]  ex = '0, ey = '0, vx = '0, vy = '0, bx = 10'd1000, by = 10'd1000;
  logic        on, hit, ovf;
  logic [11:0] rgb;
  logic [2:0]  cnt;
  int          checks = 0;
  int          errors = 0;

  explosion_ctrl #(
    .NUM_SLOTS      (4),
    .EXPLOSION_TIME (10),
    .RANGE          (2)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .explosion_write_enable (we),
    .exploding_bomb_x       (ex),
    .exploding_bomb_y       (ey),
    .v_x                    (vx),
    .v_y                    (vy),
    .b_x                    (bx),
    .b_y                    (by),
    .explosion_on           (on),
    .rgb_out                (rgb),
    .player_hit             (hit),
    .overflow               (ovf),
    .active_count           (cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we    = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic write_bomb(input logic [9:0] x, input logic [9:0] y);
    we = 1'b1;
    ex = x;
    ey = y;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; we = 1'b1; ex = 10'd100; ey = 10'd200;
    vx = 10'd100; vy = 10'd200; bx = 10'd100; by = 10'd200;
    step(); step();
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL reset_on: got %b expected 0", on); end
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", hit); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    reset = 1'b0; we = 1'b0; bx = 10'd1000; by = 10'd1000;
    step();
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_write_ignored: got %0d expected 0", cnt); end
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL reset_no_flame: got %b expected 0", on); end
  endtask

  task automatic test_region();
    do_reset();
    write_bomb(10'd100, 10'd200);
    checks++; if (cnt !== 3'd1) begin errors++; $display("FAIL region_cnt: got %0d expected 1", cnt); end
    vx = 10'd132; vy = 10'd200; step();
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL region_132: got %b expected 1", on); end
    checks++; if (rgb !== C_ON) begin errors++; $display("FAIL region_rgb: got %h expected %h", rgb, C_ON); end
    vx = 10'd149; vy = 10'd200; step();
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL region_149: got %b expected 0", on); end
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL region_rgb_off: got %h expected 000", rgb); end
    vx = 10'd100; vy = 10'd168; step();
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL region_vtop: got %b expected 1", on); end
    vx = 10'd67; vy = 10'd200; step();
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL region_hleft_out: got %b expected 0", on); end
  endtask

  task automatic test_expiry();
    do_reset();
    vx = 10'd300; vy = 10'd300;
    write_bomb(10'd300, 10'd300);
    checks++; if (cnt !== 3'd1) begin errors++; $display("FAIL expiry_start: got %0d expected 1", cnt); end
    repeat (9) step();
    checks++; if (cnt !== 3'd1) begin errors++; $display("FAIL expiry_last_burn: got %0d expected 1", cnt); end
    step();
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL expiry_idle: got %0d expected 0", cnt); end
    step();
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL expiry_on: got %b expected 0", on); end
  endtask

  task automatic test_overflow();
    do_reset();
    vx = 10'd0; vy = 10'd1000;
    write_bomb(10'd10, 10'd10);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_w1: got %b expected 0", ovf); end
    write_bomb(10'd300, 10'd10);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_w2: got %b expected 0", ovf); end
    write_bomb(10'd600, 10'd10);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_w3: got %b expected 0", ovf); end
    write_bomb(10'd900, 10'd10);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_w4: got %b expected 0", ovf); end
    checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL ovf_cnt4: got %0d expected 4", cnt); end
    write_bomb(10'd450, 10'd600);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_w5: got %b expected 1", ovf); end
    checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL ovf_cnt_w5: got %0d expected 4", cnt); end
    step();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got %b expected 0", ovf); end
    repeat (4) step();
    // Slot 0 is in its last burning cycle now.
    write_bomb(10'd800, 10'd100);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_expiring: got %b expected 1", ovf); end
    checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL ovf_cnt_expiring: got %0d expected 3", cnt); end
    write_bomb(10'd500, 10'd400);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_reuse: got %b expected 0", ovf); end
    checks++; if (cnt !== 3'd3) begin errors++; $display("FAIL ovf_cnt_reuse: got %0d expected 3", cnt); end
    vx = 10'd500; vy = 10'd400; step();
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL ovf_captured: got %b expected 1", on); end
    vx = 10'd800; vy = 10'd100; step();
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got %b expected 0", on); end
  endtask

  task automatic test_wrap();
    do_reset();
    write_bomb(10'd0, 10'd0);
    vx = 10'd1000; vy = 10'd5; step();
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL wrap_1000: got %b expected 0", on); end
    vx = 10'd0; vy = 10'd31; step();
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL wrap_0_31: got %b expected 1", on); end
    vx = 10'd47; vy = 10'd0; step();
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL wrap_47: got %b expected 1", on); end
    vx = 10'd48; vy = 10'd0; step();
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL wrap_48: got %b expected 0", on); end
  endtask

  task automatic test_player_hit();
    do_reset();
    vx = 10'd0; vy = 10'd1000;
    bx = 10'd148; by = 10'd216;
    write_bomb(10'd100, 10'd200);
    step(); step();
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_corner_miss: got %b expected 0", hit); end
    bx = 10'd132; by = 10'd216; step(); step();
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_below_miss: got %b expected 0", hit); end
    bx = 10'd116; by = 10'd200; step();
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_set: got %b expected 1", hit); end
    bx = 10'd1000; by = 10'd1000;
    repeat (12) step();
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL hit_expired_cnt: got %0d expected 0", cnt); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_sticky: got %b expected 1", hit); end
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_reset: got %b expected 0", hit); end
  endtask

  task automatic test_reset_midburn();
    do_reset();
    vx = 10'd100; vy = 10'd200;
    write_bomb(10'd100, 10'd200);
    step();
    checks++; if (on !== 1'b1) begin errors++; $display("FAIL midburn_on: got %b expected 1", on); end
    reset = 1'b1; we = 1'b1; ex = 10'd500; ey = 10'd500;
    step();
    reset = 1'b0; we = 1'b0;
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL midburn_cnt: got %0d expected 0", cnt); end
    vx = 10'd500; vy = 10'd500; step();
    checks++; if (on !== 1'b0) begin errors++; $display("FAIL midburn_write_ignored: got %b expected 0", on); end
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL midburn_cnt_after: got %0d expected 0", cnt); end
  endtask

  initial begin
    test_reset();
    test_region();
    test_expiry();
    test_overflow();
    test_wrap();
    test_player_hit();
    test_reset_midburn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
